// File: rtl/clint_vec.sv
// clint_vec: trap/interrupt sequencer. Decodes sync exceptions, vectored async
//   interrupts and mret, then writes mepc/mstatus/mcause through a CSR port.
// Latency: decode combinational; mepc write 2 cycles after acceptance, jump 3 cycles.
// Backpressure: stall_flag_o held while a request is decoded or a sequence runs;
//   new requests are ignored until the state machine is back in IDLE.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   irq_i, irq_en_i             level interrupt requests and per-source enables
//   inst_ecall_i, inst_ebreak_i, inst_mret_i, mem_access_misaligned_i, jump_flag_i
//                               execute-stage events
//   inst_addr_i                 address of the executing instruction
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values
//   csr_we_o/waddr_o/wdata_o    registered CSR write port
//   stall_flag_o, int_assert_o, int_addr_o  pipeline control
// Optional feature: define CLINT_VECTORED_EN to enable vectored async trap targets
//   (mtvec mode 01 jumps to base + 4*cause code).

module clint_vec #(
  parameter int NUM_IRQ     = 8,
  parameter int IRQ_BASE    = 16,
  parameter int FLUSH_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               inst_ecall_i,
  input  logic               inst_ebreak_i,
  input  logic               inst_mret_i,
  input  logic               mem_access_misaligned_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        inst_addr_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  output logic               csr_we_o,
  output logic [31:0]        csr_waddr_o,
  output logic [31:0]        csr_wdata_o,
  output logic               stall_flag_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h300;
  localparam logic [31:0] CSR_MEPC    = 32'h341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h342;

  // The oldest flush bit is the stage about to retire, so it does not block.
  localparam logic [FLUSH_DEPTH-1:0] FLUSH_OLDEST = FLUSH_DEPTH'(1) << (FLUSH_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_MRET
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            cause_q, cause_d;
  logic [FLUSH_DEPTH-1:0] flush_q, flush_d;
  logic                   csr_we_q, csr_we_d;
  logic [31:0]            csr_waddr_q, csr_waddr_d;
  logic [31:0]            csr_wdata_q, csr_wdata_d;

  // Request decode
  logic [NUM_IRQ-1:0] pend;
  logic               flush_clear;
  logic               sync_req;
  logic               async_req;
  logic               trap_req;
  logic               mret_req;
  logic [4:0]         win_idx;
  logic [4:0]         async_code;
  logic [31:0]        sync_cause;
  logic [31:0]        async_cause;
  logic [31:0]        trap_base;
  logic [31:0]        trap_target;

  always_comb begin
    pend        = irq_i & irq_en_i;
    flush_clear = ~|(flush_q & ~FLUSH_OLDEST);
    sync_req    = inst_ecall_i | inst_ebreak_i | mem_access_misaligned_i;
    async_req   = (|pend) & csr_mstatus_i[3] & flush_clear;
    trap_req    = sync_req | async_req;
    mret_req    = inst_mret_i & ~trap_req;

    // Scan downward so the lowest pending index is the last one written.
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = 5'(i);
    end
    async_code  = 5'(IRQ_BASE) + win_idx;
    async_cause = {1'b1, 26'd0, async_code};

    if (inst_ebreak_i)     sync_cause = 32'd3;
    else if (inst_ecall_i) sync_cause = 32'd11;
    else                   sync_cause = 32'd4;
  end

  // Trap target uses the cause latched at acceptance, mtvec as currently seen.
  always_comb begin
    trap_base   = {csr_mtvec_i[31:2], 2'b00};
    trap_target = trap_base;
`ifdef CLINT_VECTORED_EN
    if (cause_q[31] && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_target = trap_base + {cause_q[29:0], 2'b00};
    end
`endif
  end

  // State machine next-state and capture of address/cause
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    flush_d = (flush_q << 1) | FLUSH_DEPTH'(jump_flag_i);
    case (state_q)
      S_IDLE: begin
        if (trap_req) begin
          state_d = S_MEPC;
          addr_d  = inst_addr_i;
          cause_d = sync_req ? sync_cause : async_cause;
        end else if (mret_req) begin
          state_d = S_MRET;
        end
      end
      S_MEPC:    state_d = S_MSTATUS;
      S_MSTATUS: state_d = S_MCAUSE;
      S_MCAUSE:  state_d = S_IDLE;
      S_MRET:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // CSR write port, registered one cycle behind the state
  always_comb begin
    csr_we_d    = 1'b0;
    csr_waddr_d = '0;
    csr_wdata_d = '0;
    case (state_q)
      S_MEPC: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MEPC;
        csr_wdata_d = addr_q;
      end
      S_MSTATUS: begin
        csr_we_d       = 1'b1;
        csr_waddr_d    = CSR_MSTATUS;
        csr_wdata_d    = csr_mstatus_i;
        csr_wdata_d[7] = csr_mstatus_i[3];
        csr_wdata_d[3] = 1'b0;
      end
      S_MCAUSE: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      S_MRET: begin
        csr_we_d       = 1'b1;
        csr_waddr_d    = CSR_MSTATUS;
        csr_wdata_d    = csr_mstatus_i;
        csr_wdata_d[3] = csr_mstatus_i[7];
        csr_wdata_d[7] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cause_q     <= '0;
      flush_q     <= '0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cause_q     <= cause_d;
      flush_q     <= flush_d;
      csr_we_q    <= csr_we_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  always_comb begin
    csr_we_o     = csr_we_q;
    csr_waddr_o  = csr_waddr_q;
    csr_wdata_o  = csr_wdata_q;
    stall_flag_o = trap_req | mret_req | (state_q != S_IDLE);
    int_assert_o = (state_q == S_MCAUSE) | (state_q == S_MRET);
    int_addr_o   = '0;
    if (state_q == S_MCAUSE)    int_addr_o = trap_target;
    else if (state_q == S_MRET) int_addr_o = csr_mepc_i;
  end

endmodule

// File: tb/tb_clint_vec.sv
// tb_clint_vec: scoreboard bench for clint_vec; stimulus pushes expected CSR
//   writes and jump targets, a negedge monitor pops and compares them.
// Directed vectors cover ecall timing, priority, vectoring, flush, mret and reset.

module tb_clint_vec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_i, irq_en_i;
  logic        inst_ecall_i, inst_ebreak_i, inst_mret_i;
  logic        mem_access_misaligned_i, jump_flag_i;
  logic [31:0] inst_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_we_o, stall_flag_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } csr_exp_t;

  csr_exp_t    csr_q[$];
  logic [31:0] ia_q[$];

  always #5 clk = ~clk;

  clint_vec #(.NUM_IRQ(8), .IRQ_BASE(16), .FLUSH_DEPTH(4)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .irq_i                   (irq_i),
    .irq_en_i                (irq_en_i),
    .inst_ecall_i            (inst_ecall_i),
    .inst_ebreak_i           (inst_ebreak_i),
    .inst_mret_i             (inst_mret_i),
    .mem_access_misaligned_i (mem_access_misaligned_i),
    .jump_flag_i             (jump_flag_i),
    .inst_addr_i             (inst_addr_i),
    .csr_mtvec_i             (csr_mtvec_i),
    .csr_mepc_i              (csr_mepc_i),
    .csr_mstatus_i           (csr_mstatus_i),
    .csr_we_o                (csr_we_o),
    .csr_waddr_o             (csr_waddr_o),
    .csr_wdata_o             (csr_wdata_o),
    .stall_flag_o            (stall_flag_o),
    .int_assert_o            (int_assert_o),
    .int_addr_o              (int_addr_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference mstatus transforms
  function automatic logic [31:0] mst_trap(input logic [31:0] m);
    logic [31:0] r;
    r    = m & ~32'h88;
    r[7] = m[3];
    return r;
  endfunction

  function automatic logic [31:0] mst_mret(input logic [31:0] m);
    logic [31:0] r;
    r    = (m & ~32'h88) | 32'h80;
    r[3] = m[7];
    return r;
  endfunction

  task automatic expect_trap(input logic [31:0] addr, input logic [31:0] mst,
                             input logic [31:0] cause, input logic [31:0] target);
    csr_q.push_back('{a: 32'h341, d: addr});
    csr_q.push_back('{a: 32'h300, d: mst_trap(mst)});
    csr_q.push_back('{a: 32'h342, d: cause});
    ia_q.push_back(target);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    chk({name, "_csr_q_empty"}, 32'(csr_q.size()), 32'd0);
    chk({name, "_ia_q_empty"}, 32'(ia_q.size()), 32'd0);
  endtask

  // Monitor: every CSR write and every int_assert cycle must match the next
  // expected entry; anything unexpected is an error.
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we_o) begin
        if (csr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL csr_unexpected: got addr %h data %h, expected no write",
                   csr_waddr_o, csr_wdata_o);
        end else begin
          csr_exp_t e;
          e = csr_q.pop_front();
          chk("csr_waddr", csr_waddr_o, e.a);
          chk("csr_wdata", csr_wdata_o, e.d);
        end
      end
      if (int_assert_o) begin
        if (ia_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL int_assert_unexpected: got addr %h, expected no assert", int_addr_o);
        end else begin
          logic [31:0] t;
          t = ia_q.pop_front();
          chk("int_addr", int_addr_o, t);
        end
      end
    end
  end

  initial begin
    logic [31:0] vec_target;
    rst_n = 1'b0;
    irq_i = '0; irq_en_i = '0;
    inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0;
    mem_access_misaligned_i = 0; jump_flag_i = 0;
    inst_addr_i = '0; csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csr_we", 32'(csr_we_o), 32'd0);
    chk("rst_csr_waddr", csr_waddr_o, 32'd0);
    chk("rst_csr_wdata", csr_wdata_o, 32'd0);
    chk("rst_int_assert", 32'(int_assert_o), 32'd0);
    chk("rst_int_addr", int_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_flag_o), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Ecall with exact cycle timing (T = ecall cycle)
    inst_addr_i  = 32'h100;
    inst_ecall_i = 1;
    expect_trap(32'h100, 32'h0, 32'd11, 32'h200);
    @(negedge clk);
    chk("ecall_stall_T", 32'(stall_flag_o), 32'd1);
    step(1);
    inst_ecall_i = 0;
    @(negedge clk);
    chk("ecall_no_assert_T1", 32'(int_assert_o), 32'd0);
    @(negedge clk);
    chk("ecall_mepc_we_T2", 32'(csr_we_o), 32'd1);
    chk("ecall_mepc_addr_T2", csr_waddr_o, 32'h341);
    @(negedge clk);
    chk("ecall_assert_T3", 32'(int_assert_o), 32'd1);
    chk("ecall_target_T3", int_addr_o, 32'h200);
    chk("ecall_mstatus_addr_T3", csr_waddr_o, 32'h300);
    @(negedge clk);
    chk("ecall_mcause_addr_T4", csr_waddr_o, 32'h342);
    chk("ecall_mcause_data_T4", csr_wdata_o, 32'd11);
    step(3);
    drained("ecall");

    // Priority: sources 2 and 3 pending, source 2 wins
    csr_mstatus_i = 32'h8;
    irq_en_i      = 8'hFF;
    inst_addr_i   = 32'h104;
    irq_i         = 8'h0C;
    expect_trap(32'h104, 32'h8, 32'h8000_0012, 32'h200);
    step(1);
    irq_i = 8'h00;
    step(6);
    drained("prio");

    // Vectored target for source 0
    csr_mtvec_i = 32'h1001;
    inst_addr_i = 32'h108;
`ifdef CLINT_VECTORED_EN
    vec_target = 32'h1040;
`else
    vec_target = 32'h1000;
`endif
    irq_i = 8'h01;
    expect_trap(32'h108, 32'h8, 32'h8000_0010, vec_target);
    step(1);
    irq_i = 8'h00;
    step(6);
    drained("vector");
    csr_mtvec_i = 32'h200;

    // Mret alone
    csr_mstatus_i = 32'h80;
    csr_mepc_i    = 32'h3000;
    inst_mret_i   = 1;
    csr_q.push_back('{a: 32'h300, d: mst_mret(32'h80)});
    ia_q.push_back(32'h3000);
    @(negedge clk);
    chk("mret_stall", 32'(stall_flag_o), 32'd1);
    step(1);
    inst_mret_i = 0;
    step(4);
    drained("mret");

    // Mret and irq together: irq wins
    csr_mstatus_i = 32'h8;
    inst_addr_i   = 32'h10C;
    inst_mret_i   = 1;
    irq_i         = 8'h80;
    expect_trap(32'h10C, 32'h8, 32'h8000_0017, 32'h200);
    step(1);
    inst_mret_i = 0;
    irq_i       = 8'h00;
    step(6);
    drained("mret_irq");

    // Flush window blocks async acceptance for three cycles
    inst_addr_i = 32'h110;
    jump_flag_i = 1;
    step(1);
    jump_flag_i = 0;
    irq_i       = 8'h01;
    expect_trap(32'h110, 32'h8, 32'h8000_0010, 32'h200);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush_blocked_%0d", k), 32'(stall_flag_o), 32'd0);
      step(1);
    end
    @(negedge clk);
    chk("flush_clear_accept", 32'(stall_flag_o), 32'd1);
    step(1);
    irq_i = 8'h00;
    step(6);
    drained("flush");

    // Ebreak during flush window: taken first, irq follows after return
    inst_addr_i = 32'h114;
    jump_flag_i = 1;
    step(1);
    jump_flag_i   = 0;
    irq_i         = 8'h01;
    inst_ebreak_i = 1;
    expect_trap(32'h114, 32'h8, 32'd3, 32'h200);
    expect_trap(32'h114, 32'h8, 32'h8000_0010, 32'h200);
    step(1);
    inst_ebreak_i = 0;
    step(4);
    irq_i = 8'h00;
    step(8);
    drained("flush_ebreak");

    // Reset in MSTATUS aborts the sequence
    inst_addr_i  = 32'h118;
    inst_ecall_i = 1;
    csr_q.push_back('{a: 32'h341, d: 32'h118});
    step(1);
    inst_ecall_i = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_csr_we", 32'(csr_we_o), 32'd0);
    chk("mid_rst_csr_waddr", csr_waddr_o, 32'd0);
    chk("mid_rst_csr_wdata", csr_wdata_o, 32'd0);
    chk("mid_rst_int_assert", 32'(int_assert_o), 32'd0);
    chk("mid_rst_int_addr", int_addr_o, 32'd0);
    chk("mid_rst_stall", 32'(stall_flag_o), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(6);
    drained("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
